// File: rtl/pdm_capture_ctrl_if.sv
// Window-sum handshake between the PDM capture sequencer and its consumer.
// The master drives the sum and its valid flag; the slave answers with ready.
interface pdm_capture_ctrl_if #(
    parameter int WIN_LOG2 = 7
);
    logic [WIN_LOG2:0] sum_o;
    logic              sum_valid_o;
    logic              sum_ready_i;

    modport master (
        output sum_o,
        output sum_valid_o,
        input  sum_ready_i
    );

    modport slave (
        input  sum_o,
        input  sum_valid_o,
        output sum_ready_i
    );
endinterface

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone sequencer: divides clk_i down to the mic clock, waits out the wake-up time,
// then counts ones over fixed windows and offers each window sum on a valid/ready handshake.
module pdm_capture_ctrl #(
    parameter int HALF_PERIOD = 20,
    parameter int WAKE_CYCLES = 25000,
    parameter int WIN_LOG2    = 7
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                clr_i,
    output logic                m_clk_o,
    output logic                m_lrsel_o,
    input  logic                m_data_i,
    output logic                sample_o,
    output logic [WIN_LOG2-1:0] peak_o,
    output logic                overrun_o,
    output logic [1:0]          state_o,
    pdm_capture_ctrl_if.master  sum_bus
);

    localparam int DIV_W  = $clog2(HALF_PERIOD);
    localparam int WAKE_W = ($clog2(WAKE_CYCLES) > 0) ? $clog2(WAKE_CYCLES) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(HALF_PERIOD - 1);
    localparam logic [WAKE_W-1:0]   WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [WIN_LOG2-1:0] CNT_LAST  = '1;
    localparam logic [WIN_LOG2:0]   CENTER    = (WIN_LOG2 + 1)'(2 ** (WIN_LOG2 - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic                r_mclk;
    logic [WAKE_W-1:0]   r_wake;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [WIN_LOG2:0]   r_ones;
    logic [WIN_LOG2:0]   r_sum;
    logic                r_valid;
    logic [WIN_LOG2-1:0] r_peak;
    logic                r_overrun;
    logic                r_sample;

    logic              w_div_wrap;
    logic              w_fall;
    logic              w_capture;
    logic              w_last;
    logic              w_done;
    logic              w_xfer;
    logic [WIN_LOG2:0] w_sum;
    logic [WIN_LOG2:0] w_dev;

    // A mic-clock falling edge is the divider wrapping while the clock is high.
    assign w_div_wrap = (r_div == DIV_LAST);
    assign w_fall     = (r_state != ST_IDLE) && en_i && w_div_wrap && r_mclk;
    assign w_capture  = (r_state == ST_RUN) && w_fall;
    assign w_last     = w_capture && (r_cnt == CNT_LAST);
    assign w_done     = w_last && !clr_i;
    assign w_xfer     = r_valid && sum_bus.sum_ready_i;
    assign w_sum      = r_ones + {{WIN_LOG2{1'b0}}, m_data_i};
    assign w_dev      = (w_sum >= CENTER) ? (w_sum - CENTER) : (CENTER - w_sum);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_mclk    <= 1'b0;
            r_wake    <= '0;
            r_cnt     <= '0;
            r_ones    <= '0;
            r_sum     <= '0;
            r_valid   <= 1'b0;
            r_peak    <= '0;
            r_overrun <= 1'b0;
            r_sample  <= 1'b0;
        end else begin
            r_sample <= w_capture;
            if (r_state == ST_IDLE) begin
                r_div  <= '0;
                r_mclk <= 1'b0;
                r_wake <= '0;
                r_cnt  <= '0;
                r_ones <= '0;
                if (en_i)
                    r_state <= ST_WAKE;
            end else if (!en_i) begin
                r_state <= ST_IDLE;
                r_div   <= '0;
                r_mclk  <= 1'b0;
                r_wake  <= '0;
                r_cnt   <= '0;
                r_ones  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
                if (w_div_wrap)
                    r_mclk <= ~r_mclk;

                if (r_state == ST_WAKE && w_fall) begin
                    if (r_wake == WAKE_LAST) begin
                        r_state <= ST_RUN;
                        r_wake  <= '0;
                    end else begin
                        r_wake <= r_wake + WAKE_W'(1);
                    end
                end

                if (clr_i) begin
                    r_cnt  <= '0;
                    r_ones <= '0;
                end else if (w_capture) begin
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_ones <= '0;
                    end else begin
                        r_cnt  <= r_cnt + WIN_LOG2'(1);
                        r_ones <= w_sum;
                    end
                end

                // A finished window is accepted only if the output slot is free or emptying this cycle.
                if (w_done && (!r_valid || w_xfer)) begin
                    r_sum   <= w_sum;
                    r_valid <= 1'b1;
                end else if (w_done) begin
                    r_overrun <= 1'b1;
                end else if (w_xfer) begin
                    r_valid <= 1'b0;
                end

                if (w_done && (w_dev > {1'b0, r_peak}))
                    r_peak <= w_dev[WIN_LOG2-1:0];
            end

            if (clr_i) begin
                r_peak    <= '0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign m_clk_o             = r_mclk;
    assign m_lrsel_o           = 1'b0;
    assign sample_o            = r_sample;
    assign peak_o              = r_peak;
    assign overrun_o           = r_overrun;
    assign state_o             = r_state;
    assign sum_bus.sum_o       = r_sum;
    assign sum_bus.sum_valid_o = r_valid;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl with HALF_PERIOD=2, WAKE_CYCLES=3, WIN_LOG2=3.
module tb_pdm_capture_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic       en_i;
    logic       clr_i;
    logic       m_clk_o;
    logic       m_lrsel_o;
    logic       m_data_i;
    logic       sample_o;
    logic [2:0] peak_o;
    logic       overrun_o;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    pdm_capture_ctrl_if #(.WIN_LOG2(3)) bus ();

    pdm_capture_ctrl #(
        .HALF_PERIOD(2),
        .WAKE_CYCLES(3),
        .WIN_LOG2   (3)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .m_clk_o  (m_clk_o),
        .m_lrsel_o(m_lrsel_o),
        .m_data_i (m_data_i),
        .sample_o (sample_o),
        .peak_o   (peak_o),
        .overrun_o(overrun_o),
        .state_o  (state_o),
        .sum_bus  (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Presents pat[i] for each of n successive captures; returns just after the nth capture edge.
    task automatic feed(input logic [7:0] pat, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            m_data_i = pat[i];
            guard = 0;
            do begin
                step(1);
                guard++;
            end while (sample_o !== 1'b1 && guard < 20);
            total++;
            if (sample_o !== 1'b1) begin
                bad++;
                $display("[TB] FAIL feed_sample_timeout: got sample_o=%b want 1 (sample %0d)", sample_o, i);
                return;
            end
        end
    endtask

    task automatic wait_run(output int k);
        k = 0;
        while (state_o !== 2'd2 && k < 100) begin
            step(1);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        en_i = 1'b0;
        clr_i = 1'b0;
        m_data_i = 1'b0;
        bus.sum_ready_i = 1'b0;
        step(2);
        total++;
        if ({m_clk_o, m_lrsel_o, sample_o, overrun_o} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {m_clk_o, m_lrsel_o, sample_o, overrun_o});
        end
        total++;
        if (bus.sum_o !== 4'd0 || bus.sum_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_sum: got sum=%0d valid=%b want 0/0", bus.sum_o, bus.sum_valid_o);
        end
        total++;
        if (peak_o !== 3'd0 || state_o !== 2'd0) begin
            bad++;
            $display("[TB] FAIL reset_peak_state: got peak=%0d state=%0d want 0/0", peak_o, state_o);
        end
        rst_ni = 1'b1;
        step(1);
    endtask

    task automatic test_wake_run();
        int k;
        int n;
        int rise1;
        int rise2;
        logic prev;
        en_i = 1'b1;
        m_data_i = 1'b1;
        step(1);
        total++;
        if (state_o !== 2'd1 || m_clk_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wake_entry: got state=%0d mclk=%b want 1/0", state_o, m_clk_o);
        end
        k = 0;
        rise1 = -1;
        rise2 = -1;
        prev = 1'b0;
        while (state_o !== 2'd2 && k < 100) begin
            step(1);
            k++;
            if (m_clk_o === 1'b1 && prev === 1'b0) begin
                if (rise1 < 0) rise1 = k;
                else if (rise2 < 0) rise2 = k;
            end
            prev = m_clk_o;
        end
        total++;
        if (rise1 != 2) begin
            bad++;
            $display("[TB] FAIL first_rise: got cycle %0d want 2", rise1);
        end
        total++;
        if (rise2 - rise1 != 4) begin
            bad++;
            $display("[TB] FAIL mclk_period: got %0d want 4", rise2 - rise1);
        end
        total++;
        if (k != 12) begin
            bad++;
            $display("[TB] FAIL wake_length: got %0d cycles want 12", k);
        end
        n = 0;
        k = 0;
        while (bus.sum_valid_o !== 1'b1 && k < 100) begin
            step(1);
            k++;
            if (sample_o === 1'b1) n++;
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("[TB] FAIL first_window_samples: got %0d want 8", n);
        end
        total++;
        if (bus.sum_o !== 4'd8 || bus.sum_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL first_window_sum: got sum=%0d valid=%b want 8/1", bus.sum_o, bus.sum_valid_o);
        end
        total++;
        if (peak_o !== 3'd4 || overrun_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL first_window_peak: got peak=%0d ovr=%b want 4/0", peak_o, overrun_o);
        end
    endtask

    task automatic test_patterns();
        bus.sum_ready_i = 1'b1;
        step(1);
        total++;
        if (bus.sum_valid_o !== 1'b0 || bus.sum_o !== 4'd8) begin
            bad++;
            $display("[TB] FAIL transfer_drop_valid: got valid=%b sum=%0d want 0/8", bus.sum_valid_o, bus.sum_o);
        end
        feed(8'h00, 8);
        total++;
        if (bus.sum_o !== 4'd0 || bus.sum_valid_o !== 1'b1 || peak_o !== 3'd4) begin
            bad++;
            $display("[TB] FAIL zeros_window: got sum=%0d valid=%b peak=%0d want 0/1/4", bus.sum_o, bus.sum_valid_o, peak_o);
        end
        feed(8'b0101_0101, 8);
        total++;
        if (bus.sum_o !== 4'd4 || bus.sum_valid_o !== 1'b1 || peak_o !== 3'd4) begin
            bad++;
            $display("[TB] FAIL alt_window: got sum=%0d valid=%b peak=%0d want 4/1/4", bus.sum_o, bus.sum_valid_o, peak_o);
        end
    endtask

    task automatic test_overrun();
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        bus.sum_ready_i = 1'b0;
        total++;
        if (peak_o !== 3'd0 || overrun_o !== 1'b0 || bus.sum_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pre_overrun_clear: got peak=%0d ovr=%b valid=%b want 0/0/0", peak_o, overrun_o, bus.sum_valid_o);
        end
        feed(8'b0001_1111, 8);
        total++;
        if (bus.sum_o !== 4'd5 || bus.sum_valid_o !== 1'b1 || peak_o !== 3'd1 || overrun_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sum5: got sum=%0d valid=%b peak=%0d ovr=%b want 5/1/1/0", bus.sum_o, bus.sum_valid_o, peak_o, overrun_o);
        end
        feed(8'b0111_1111, 8);
        total++;
        if (bus.sum_o !== 4'd5 || overrun_o !== 1'b1 || peak_o !== 3'd3) begin
            bad++;
            $display("[TB] FAIL overrun: got sum=%0d ovr=%b peak=%0d want 5/1/3", bus.sum_o, overrun_o, peak_o);
        end
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        total++;
        if (peak_o !== 3'd0 || overrun_o !== 1'b0 || bus.sum_valid_o !== 1'b1 || bus.sum_o !== 4'd5) begin
            bad++;
            $display("[TB] FAIL clear: got peak=%0d ovr=%b valid=%b sum=%0d want 0/0/1/5", peak_o, overrun_o, bus.sum_valid_o, bus.sum_o);
        end
    endtask

    task automatic test_back_to_back();
        feed(8'b0000_0011, 7);
        m_data_i = 1'b0;
        step(3);
        bus.sum_ready_i = 1'b1;
        step(1);
        bus.sum_ready_i = 1'b0;
        total++;
        if (sample_o !== 1'b1 || bus.sum_o !== 4'd2 || bus.sum_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL coincident_xfer: got smp=%b sum=%0d valid=%b want 1/2/1", sample_o, bus.sum_o, bus.sum_valid_o);
        end
        total++;
        if (overrun_o !== 1'b0 || peak_o !== 3'd2) begin
            bad++;
            $display("[TB] FAIL coincident_flags: got ovr=%b peak=%0d want 0/2", overrun_o, peak_o);
        end
        step(1);
        total++;
        if (bus.sum_valid_o !== 1'b1 || bus.sum_o !== 4'd2) begin
            bad++;
            $display("[TB] FAIL hold_valid: got valid=%b sum=%0d want 1/2", bus.sum_valid_o, bus.sum_o);
        end
    endtask

    task automatic test_disable();
        int k;
        feed(8'hFF, 5);
        en_i = 1'b0;
        step(1);
        total++;
        if (state_o !== 2'd0 || m_clk_o !== 1'b0 || bus.sum_valid_o !== 1'b0 || peak_o !== 3'd2) begin
            bad++;
            $display("[TB] FAIL disable: got state=%0d mclk=%b valid=%b peak=%0d want 0/0/0/2", state_o, m_clk_o, bus.sum_valid_o, peak_o);
        end
        step(3);
        total++;
        if (state_o !== 2'd0 || m_clk_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_hold: got state=%0d mclk=%b want 0/0", state_o, m_clk_o);
        end
        en_i = 1'b1;
        step(1);
        wait_run(k);
        total++;
        if (k != 12) begin
            bad++;
            $display("[TB] FAIL rewake_length: got %0d cycles want 12", k);
        end
        feed(8'b0000_0001, 8);
        total++;
        if (bus.sum_o !== 4'd1 || bus.sum_valid_o !== 1'b1 || peak_o !== 3'd3) begin
            bad++;
            $display("[TB] FAIL fresh_window: got sum=%0d valid=%b peak=%0d want 1/1/3", bus.sum_o, bus.sum_valid_o, peak_o);
        end
    endtask

    task automatic test_clear_complete();
        int guard;
        bus.sum_ready_i = 1'b1;
        step(1);
        bus.sum_ready_i = 1'b0;
        total++;
        if (bus.sum_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drain: got valid=%b want 0", bus.sum_valid_o);
        end
        feed(8'hFF, 7);
        m_data_i = 1'b1;
        step(3);
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        total++;
        if (sample_o !== 1'b1 || bus.sum_valid_o !== 1'b0 || bus.sum_o !== 4'd1) begin
            bad++;
            $display("[TB] FAIL clr_at_complete: got smp=%b valid=%b sum=%0d want 1/0/1", sample_o, bus.sum_valid_o, bus.sum_o);
        end
        total++;
        if (peak_o !== 3'd0 || overrun_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clr_at_complete_flags: got peak=%0d ovr=%b want 0/0", peak_o, overrun_o);
        end
        feed(8'b0000_0111, 8);
        total++;
        if (bus.sum_o !== 4'd3 || bus.sum_valid_o !== 1'b1 || peak_o !== 3'd1) begin
            bad++;
            $display("[TB] FAIL after_clr_window: got sum=%0d valid=%b peak=%0d want 3/1/1", bus.sum_o, bus.sum_valid_o, peak_o);
        end
        guard = 0;
        while (m_clk_o !== 1'b1 && guard < 10) begin
            step(1);
            guard++;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({m_clk_o, sample_o, overrun_o, bus.sum_valid_o} !== 4'b0 || state_o !== 2'd0) begin
            bad++;
            $display("[TB] FAIL async_reset_flags: got mclk=%b smp=%b ovr=%b valid=%b state=%0d want all 0",
                     m_clk_o, sample_o, overrun_o, bus.sum_valid_o, state_o);
        end
        total++;
        if (bus.sum_o !== 4'd0 || peak_o !== 3'd0) begin
            bad++;
            $display("[TB] FAIL async_reset_data: got sum=%0d peak=%0d want 0/0", bus.sum_o, peak_o);
        end
        step(1);
        rst_ni = 1'b1;
        en_i = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_wake_run();
        test_patterns();
        test_overrun();
        test_back_to_back();
        test_disable();
        test_clear_complete();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
